// File: rtl/mac_addr_source.sv
// Source-side operand streamer for the MAC engine. A start from the controller latches a
// two-level (line/feature) address pattern, word reads are issued to the TCDM port under
// a credit limit, and returned data is replayed in order from a small FIFO as a
// valid/ready stream.
module mac_addr_source #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              req_start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  trans_size_i,
  input  logic [CNT_W-1:0]  line_length_i,
  input  logic [ADDR_W-1:0] line_stride_i,
  input  logic [CNT_W-1:0]  feat_length_i,
  input  logic [ADDR_W-1:0] feat_stride_i,
  output logic              ready_start_o,
  output logic              done_o,
  output logic              tcdm_req_o,
  output logic [ADDR_W-1:0] tcdm_add_o,
  input  logic              tcdm_gnt_i,
  input  logic              tcdm_r_valid_i,
  input  logic [DATA_W-1:0] tcdm_r_data_i,
  output logic              stream_valid_o,
  input  logic              stream_ready_i,
  output logic [DATA_W-1:0] stream_data_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [ADDR_W-1:0] Step = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  trans_size_q, line_len_q, feat_len_q;
  logic [ADDR_W-1:0] line_stride_q, feat_stride_q;
  logic [ADDR_W-1:0] addr_q, addr_d, line_base_q, line_base_d, feat_base_q, feat_base_d;
  logic [CNT_W-1:0]  word_cnt_q, line_cnt_q, line_cnt_d, feat_line_cnt_q, feat_line_cnt_d;
  logic              inflight_q, done_zero_q;

  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]   fifo_cnt_q;
  logic [OccW:0]     occupancy;

  logic start_acc, grant, last_word, line_end, feat_end, credit_ok;
  logic fifo_empty, fifo_full, push, pop, drain_done;

  assign start_acc  = (state_q == StIdle) && req_start_i;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == OccW'(FIFO_DEPTH));
  // Credit counts the FIFO plus the one read that may still be in flight; same-cycle
  // pops are deliberately not credited.
  assign occupancy  = {1'b0, fifo_cnt_q} + {{OccW{1'b0}}, inflight_q};
  assign credit_ok  = occupancy < (OccW + 1)'(FIFO_DEPTH);
  assign tcdm_req_o = (state_q == StIssue) && credit_ok;
  assign tcdm_add_o = addr_q;
  assign grant      = tcdm_req_o && tcdm_gnt_i;
  assign last_word  = word_cnt_q == trans_size_q - CNT_W'(1);
  assign line_end   = line_cnt_q == line_len_q - CNT_W'(1);
  assign feat_end   = feat_line_cnt_q == feat_len_q - CNT_W'(1);
  // Responses seen while idle belong to a cleared job and are dropped.
  assign push       = tcdm_r_valid_i && (state_q != StIdle);
  assign pop        = stream_valid_o && stream_ready_i;
  assign drain_done = (state_q == StDrain) && !inflight_q && fifo_empty;

  assign stream_valid_o = !fifo_empty;
  assign stream_data_o  = fifo_mem_q[rd_ptr_q];
  assign done_o         = done_zero_q || drain_done;
  assign ready_start_o  = (state_q == StIdle) || drain_done;

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_start_i && (trans_size_i != '0)) state_d = StIssue;
      StIssue: if (grant && last_word) state_d = StDrain;
      StDrain: if (drain_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Address step for the next granted word: inside a line, next line, or next feature.
  always_comb begin
    addr_d          = addr_q + Step;
    line_base_d     = line_base_q;
    feat_base_d     = feat_base_q;
    line_cnt_d      = line_cnt_q + CNT_W'(1);
    feat_line_cnt_d = feat_line_cnt_q;
    if (line_end) begin
      line_cnt_d = '0;
      if (feat_end) begin
        addr_d          = feat_base_q + feat_stride_q;
        line_base_d     = addr_d;
        feat_base_d     = addr_d;
        feat_line_cnt_d = '0;
      end else begin
        addr_d          = line_base_q + line_stride_q;
        line_base_d     = addr_d;
        feat_line_cnt_d = feat_line_cnt_q + CNT_W'(1);
      end
    end
  end

  // Sequencer state, in-flight flag and zero-length done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      inflight_q  <= 1'b0;
      done_zero_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= StIdle;
      inflight_q  <= 1'b0;
      done_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= grant;
      done_zero_q <= start_acc && (trans_size_i == '0);
    end
  end

  // Job configuration; zero lengths collapse to one so the line/feature walk terminates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trans_size_q  <= '0;
      line_len_q    <= '0;
      feat_len_q    <= '0;
      line_stride_q <= '0;
      feat_stride_q <= '0;
    end else if (clear_i) begin
      trans_size_q  <= '0;
      line_len_q    <= '0;
      feat_len_q    <= '0;
      line_stride_q <= '0;
      feat_stride_q <= '0;
    end else if (start_acc) begin
      trans_size_q  <= trans_size_i;
      line_len_q    <= (line_length_i == '0) ? CNT_W'(1) : line_length_i;
      feat_len_q    <= (feat_length_i == '0) ? CNT_W'(1) : feat_length_i;
      line_stride_q <= line_stride_i;
      feat_stride_q <= feat_stride_i;
    end
  end

  // Address walker and word/line/feature counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q          <= '0;
      line_base_q     <= '0;
      feat_base_q     <= '0;
      word_cnt_q      <= '0;
      line_cnt_q      <= '0;
      feat_line_cnt_q <= '0;
    end else if (clear_i) begin
      addr_q          <= '0;
      line_base_q     <= '0;
      feat_base_q     <= '0;
      word_cnt_q      <= '0;
      line_cnt_q      <= '0;
      feat_line_cnt_q <= '0;
    end else if (start_acc) begin
      addr_q          <= base_addr_i;
      line_base_q     <= base_addr_i;
      feat_base_q     <= base_addr_i;
      word_cnt_q      <= '0;
      line_cnt_q      <= '0;
      feat_line_cnt_q <= '0;
    end else if (grant) begin
      addr_q          <= addr_d;
      line_base_q     <= line_base_d;
      feat_base_q     <= feat_base_d;
      word_cnt_q      <= word_cnt_q + CNT_W'(1);
      line_cnt_q      <= line_cnt_d;
      feat_line_cnt_q <= feat_line_cnt_d;
    end
  end

  // Return-data FIFO pointers and fill level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + OccW'(1);
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - OccW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since the fill level guards every read.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) fifo_mem_q[wr_ptr_q] <= tcdm_r_data_i;
  end

  // A push into a full FIFO means the credit accounting is broken.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_mac_addr_source.sv
// Bench for mac_addr_source: directed jobs against a queue-based model of the expected
// address sequence, returned data order, FIFO fill level and done/ready handshake.
module tb_mac_addr_source;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          req_start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [CW-1:0] trans_size_i = '0;
  logic [CW-1:0] line_length_i = '0;
  logic [AW-1:0] line_stride_i = '0;
  logic [CW-1:0] feat_length_i = '0;
  logic [AW-1:0] feat_stride_i = '0;
  logic          ready_start_o, done_o, tcdm_req_o, stream_valid_o;
  logic [AW-1:0] tcdm_add_o;
  logic          tcdm_gnt_i = 1'b1;
  logic          tcdm_r_valid_i = 1'b0;
  logic [DW-1:0] tcdm_r_data_i = '0;
  logic          stream_ready_i = 1'b1;
  logic [DW-1:0] stream_data_o;

  always #5 clk_i = ~clk_i;

  mac_addr_source #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .req_start_i(req_start_i),
    .base_addr_i(base_addr_i), .trans_size_i(trans_size_i), .line_length_i(line_length_i),
    .line_stride_i(line_stride_i), .feat_length_i(feat_length_i),
    .feat_stride_i(feat_stride_i), .ready_start_o(ready_start_o), .done_o(done_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
    .stream_data_o(stream_data_o)
  );

  int checks = 0;
  int errors = 0;

  // Model state.
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int            fifo_m = 0;
  bit            inflight_m = 0;
  bit            job_active = 0;
  bit            zero_pend = 0;
  int            job_grants = 0;
  int            beats = 0;
  int            done_cnt = 0;
  int            stall_seen = 0;
  int            stall_left = 0;
  logic [AW-1:0] last_addr = '0;
  bit            rv_next = 0;
  logic [DW-1:0] rd_next = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected address list: feature f starts at base + f*feat_stride, line l of a feature at
  // feature start + l*line_stride, word w of a line at line start + 4*w.
  task automatic gen(input logic [AW-1:0] base, input int trans, input int ll,
                     input logic [AW-1:0] ls, input int fl, input logic [AW-1:0] fs);
    int l = (ll == 0) ? 1 : ll;
    int f = (fl == 0) ? 1 : fl;
    int n = 0;
    logic [AW-1:0] fb = base;
    exp_addr.delete();
    while (n < trans) begin
      for (int li = 0; li < f && n < trans; li++) begin
        for (int w = 0; w < l && n < trans; w++) begin
          exp_addr.push_back(fb + 32'(li) * ls + 32'(w * 4));
          n++;
        end
      end
      fb = fb + fs;
    end
  endtask

  // Memory responder and grant pattern, driven just after each rising edge.
  always begin
    @(posedge clk_i);
    #1;
    tcdm_r_valid_i = rv_next;
    tcdm_r_data_i  = rd_next;
    if (stall_left > 0 && job_grants == 1 && tcdm_req_o) begin
      tcdm_gnt_i = 1'b0;
      stall_left--;
    end else begin
      tcdm_gnt_i = 1'b1;
    end
  end

  // Per-cycle compare against the model, then advance the model by this cycle's events.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      bit exp_req, exp_done, grant, pop;
      exp_req = job_active && exp_addr.size() > 0 && (fifo_m + int'(inflight_m)) < DEPTH;
      chk("tcdm_req", 32'(tcdm_req_o), 32'(exp_req));
      if (tcdm_req_o && exp_addr.size() > 0) chk("tcdm_add", tcdm_add_o, exp_addr[0]);
      chk("stream_valid", 32'(stream_valid_o), 32'(fifo_m > 0));
      exp_done = zero_pend || (job_active && exp_addr.size() == 0 && fifo_m == 0 && !inflight_m);
      chk("done", 32'(done_o), 32'(exp_done));
      chk("ready_start", 32'(ready_start_o), 32'(!job_active || exp_done));
      grant = tcdm_req_o && tcdm_gnt_i;
      pop   = stream_valid_o && stream_ready_i;
      if (tcdm_req_o && !tcdm_gnt_i && tcdm_add_o == 32'h304) stall_seen++;
      if (pop) begin
        chk("stream_underrun", 32'(exp_data.size() > 0), 32'd1);
        if (exp_data.size() > 0) chk("stream_data", stream_data_o, exp_data.pop_front());
      end
      rv_next = grant;
      rd_next = mem_word(tcdm_add_o);
      if (clear_i) begin
        exp_addr.delete();
        exp_data.delete();
        fifo_m     = 0;
        inflight_m = 0;
        job_active = 0;
        zero_pend  = 0;
      end else begin
        if (grant) begin
          chk("grant_overrun", 32'(exp_addr.size() > 0), 32'd1);
          if (exp_addr.size() > 0) begin
            last_addr = exp_addr.pop_front();
            exp_data.push_back(mem_word(last_addr));
          end
          job_grants++;
        end
        if (pop) beats++;
        fifo_m     = fifo_m + int'(inflight_m) - int'(pop);
        inflight_m = grant;
        if (exp_done) begin
          job_active = 0;
          zero_pend  = 0;
          done_cnt++;
        end
      end
    end
  end

  // Called just after a rising edge with the DUT idle.
  task automatic start_job(input logic [AW-1:0] base, input int trans, input int ll,
                           input logic [AW-1:0] ls, input int fl, input logic [AW-1:0] fs);
    base_addr_i   = base;
    trans_size_i  = CW'(trans);
    line_length_i = CW'(ll);
    line_stride_i = ls;
    feat_length_i = CW'(fl);
    feat_stride_i = fs;
    job_grants    = 0;
    beats         = 0;
    req_start_i   = 1'b1;
    @(posedge clk_i);
    #1;
    req_start_i = 1'b0;
    gen(base, trans, ll, ls, fl, fs);
    if (trans != 0) job_active = 1;
    else zero_pend = 1;
  endtask

  task automatic wait_job(input string nm);
    int n = 0;
    while ((job_active || zero_pend) && n < 400) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk(nm, 32'(job_active || zero_pend), 32'd0);
  endtask

  initial begin
    int d0;
    logic [AW-1:0] t2 [6];
    t2 = '{32'h0, 32'h4, 32'h40, 32'h44, 32'h80, 32'h84};

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready_start", 32'(ready_start_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_req", 32'(tcdm_req_o), 32'd0);
    chk("rst_add", tcdm_add_o, 32'd0);
    chk("rst_valid", 32'(stream_valid_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 1: contiguous line
    d0 = done_cnt;
    start_job(32'h100, 8, 8, 32'h0, 1, 32'h0);
    chk("t1_model_first", exp_addr[0], 32'h100);
    chk("t1_model_last", exp_addr[7], 32'h11C);
    wait_job("t1_timeout");
    chk("t1_beats", 32'(beats), 32'd8);
    chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t1_last_addr", last_addr, 32'h11C);
    chk("t1_ready_after", 32'(ready_start_o), 32'd1);

    // 2: strided 2D, then feature wrap
    start_job(32'h0, 6, 2, 32'h40, 3, 32'h200);
    for (int i = 0; i < 6; i++) chk("t2_model_addr", exp_addr[i], t2[i]);
    wait_job("t2_timeout");
    chk("t2_beats", 32'(beats), 32'd6);
    start_job(32'h0, 8, 2, 32'h40, 2, 32'h200);
    chk("t2b_model_addr4", exp_addr[4], 32'h200);
    chk("t2b_model_addr7", exp_addr[7], 32'h244);
    wait_job("t2b_timeout");
    chk("t2b_last_addr", last_addr, 32'h244);

    // 3: stream backpressure
    stream_ready_i = 1'b0;
    start_job(32'h1000, 10, 10, 32'h0, 1, 32'h0);
    repeat (20) begin
      @(posedge clk_i);
      #1;
    end
    chk("t3_grants_stalled", 32'(job_grants), DEPTH);
    chk("t3_req_while_full", 32'(tcdm_req_o), 32'd0);
    stream_ready_i = 1'b1;
    wait_job("t3_timeout");
    chk("t3_beats", 32'(beats), 32'd10);
    chk("t3_last_addr", last_addr, 32'h1024);

    // 4: grant stall on the second request
    stall_seen = 0;
    stall_left = 3;
    start_job(32'h300, 5, 5, 32'h0, 1, 32'h0);
    wait_job("t4_timeout");
    chk("t4_stall_cycles_at_304", 32'(stall_seen), 32'd3);
    chk("t4_beats", 32'(beats), 32'd5);

    // 5a: zero-length job
    d0 = done_cnt;
    start_job(32'h500, 0, 1, 32'h0, 1, 32'h0);
    wait_job("t5a_timeout");
    chk("t5a_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t5a_grants", 32'(job_grants), 32'd0);

    // 5b: start pulse mid-job is ignored
    start_job(32'h600, 6, 6, 32'h0, 1, 32'h0);
    @(posedge clk_i);
    #1;
    base_addr_i  = 32'h900;
    trans_size_i = CW'(3);
    req_start_i  = 1'b1;
    @(posedge clk_i);
    #1;
    req_start_i = 1'b0;
    wait_job("t5b_timeout");
    chk("t5b_beats", 32'(beats), 32'd6);
    chk("t5b_last_addr", last_addr, 32'h614);

    // 6: clear with one read in flight, then a fresh job
    start_job(32'h700, 8, 8, 32'h0, 1, 32'h0);
    @(posedge clk_i);
    #1;
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    d0 = done_cnt;
    @(posedge clk_i);
    #1;
    chk("t6_valid_after_clear", 32'(stream_valid_o), 32'd0);
    chk("t6_ready_after_clear", 32'(ready_start_o), 32'd1);
    chk("t6_req_after_clear", 32'(tcdm_req_o), 32'd0);
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    start_job(32'h800, 4, 2, 32'h10, 2, 32'h100);
    wait_job("t6b_timeout");
    chk("t6b_beats", 32'(beats), 32'd4);
    chk("t6b_last_addr", last_addr, 32'h814);

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
